// File: rtl/sum_powers_accel_pkg.sv
`default_nettype none
// =============================================================================
// sum_powers_accel_pkg : shared types and helpers for the sum-of-powers unit
// Revision: 1.0
// =============================================================================
package sum_powers_accel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_LIN = 2'd0,
    M_SQR = 2'd1,
    M_CUB = 2'd2
  } mode_t;

  function automatic logic [63:0] max_signed(input int unsigned acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sum_powers_accel_if.sv
`default_nettype none
// =============================================================================
// sum_powers_accel_if : start/done coprocessor bus for sum_powers_accel
// Revision: 1.0
// =============================================================================
interface sum_powers_accel_if #(
  parameter int N_W   = 8,
  parameter int ACC_W = 16
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [N_W-1:0]   n;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic             ovf;
  logic [N_W-1:0]   last_k;

  modport master (
    output start, abort, mode, n,
    input  busy, done, result, ovf, last_k
  );

  modport slave (
    input  start, abort, mode, n,
    output busy, done, result, ovf, last_k
  );
endinterface
`default_nettype wire

// File: rtl/sum_powers_accel_term_gen.sv
`default_nettype none
// =============================================================================
// sum_powers_accel_term_gen : k, k^2, k^3 by forward differences, no multipliers
// Revision: 1.0
// =============================================================================
module sum_powers_accel_term_gen #(
  parameter int N_W = 8
) (
  input  logic               clk,
  input  logic               asyn_rst,
  input  logic               init,
  input  logic               step,
  output logic [N_W-1:0]     k,
  output logic [2*N_W-1:0]   sq,
  output logic [3*N_W-1:0]   cube
);
  localparam int C_SQ_W = 2 * N_W;
  localparam int C_CU_W = 3 * N_W;

  logic [N_W-1:0]    r_k;
  logic [C_SQ_W-1:0] r_sq;
  logic [C_CU_W-1:0] r_cube;

  logic [C_SQ_W-1:0] w_sq_inc;
  logic [C_CU_W-1:0] w_cube_inc;
  logic [C_CU_W-1:0] w_sq_ext;
  logic [C_CU_W-1:0] w_k_ext;

  assign w_sq_ext = C_CU_W'(r_sq);
  assign w_k_ext  = C_CU_W'(r_k);

  // (k+1)^2 - k^2 = 2k+1 ; (k+1)^3 - k^3 = 3k^2 + 3k + 1
  assign w_sq_inc   = C_SQ_W'({r_k, 1'b0}) + C_SQ_W'(1);
  assign w_cube_inc = (w_sq_ext << 1) + w_sq_ext + (w_k_ext << 1) + w_k_ext + C_CU_W'(1);

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_k    <= '0;
      r_sq   <= '0;
      r_cube <= '0;
    end else if (init) begin
      r_k    <= N_W'(1);
      r_sq   <= C_SQ_W'(1);
      r_cube <= C_CU_W'(1);
    end else if (step) begin
      r_k    <= r_k + N_W'(1);
      r_sq   <= r_sq + w_sq_inc;
      r_cube <= r_cube + w_cube_inc;
    end
  end

  assign k    = r_k;
  assign sq   = r_sq;
  assign cube = r_cube;

endmodule
`default_nettype wire

// File: rtl/sum_powers_accel.sv
`default_nettype none
// =============================================================================
// sum_powers_accel : iterative S(n) = sum k^p (p = 1..3) with overflow detection
// Revision: 1.0
// =============================================================================
module sum_powers_accel #(
  parameter int N_W      = 8,
  parameter int ACC_W    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             asyn_rst,
  sum_powers_accel_if.slave bus
);
  import sum_powers_accel_pkg::*;

  localparam int C_TERM_W = 3 * N_W + 1;
  localparam int C_SUM_W  = ((C_TERM_W > ACC_W) ? C_TERM_W : ACC_W) + 1;

  localparam logic [C_SUM_W-1:0] C_MAX_SUM = C_SUM_W'(max_signed(ACC_W));
  localparam logic [ACC_W-1:0]   C_MAX_ACC = ACC_W'(max_signed(ACC_W));

  localparam logic [1:0] C_ST_IDLE = IDLE;
  localparam logic [1:0] C_ST_RUN  = RUN;
  localparam logic [1:0] C_ST_DONE = DONE;

  logic [1:0]       r_state;
  logic [N_W-1:0]   r_n;
  mode_t            r_mode;
  logic [ACC_W-1:0] r_acc;
  logic [N_W-1:0]   r_last_k;
  logic [ACC_W-1:0] r_result;
  logic             r_ovf;
  logic [N_W-1:0]   r_last_k_out;

  logic [N_W-1:0]      w_k;
  logic [2*N_W-1:0]    w_sq;
  logic [3*N_W-1:0]    w_cube;
  logic [C_TERM_W-1:0] w_term;
  logic [C_SUM_W-1:0]  w_sum;
  logic                w_over;
  logic                w_last;
  logic                w_accept;
  logic                w_step;
  logic [ACC_W-1:0]    w_ovf_acc;

  sum_powers_accel_term_gen #(
    .N_W (N_W)
  ) u_term_gen (
    .clk      (clk),
    .asyn_rst (asyn_rst),
    .init     (w_accept),
    .step     (w_step),
    .k        (w_k),
    .sq       (w_sq),
    .cube     (w_cube)
  );

  always_comb begin
    w_term = '0;
    case (r_mode)
      M_LIN:   w_term = C_TERM_W'(w_k);
      M_CUB:   w_term = C_TERM_W'(w_cube);
      default: w_term = C_TERM_W'(w_sq);
    endcase
  end

  // Sum is wide enough that acc + largest term can never wrap before the compare.
  assign w_sum     = C_SUM_W'(r_acc) + C_SUM_W'(w_term);
  assign w_over    = (w_sum > C_MAX_SUM);
  assign w_last    = (w_k == r_n);
  assign w_accept  = (r_state == C_ST_IDLE) && bus.start;
  assign w_step    = (r_state == C_ST_RUN) && !bus.abort && !w_over && !w_last;
  assign w_ovf_acc = SATURATE ? C_MAX_ACC : r_acc;

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_state      <= C_ST_IDLE;
      r_n          <= '0;
      r_mode       <= M_LIN;
      r_acc        <= '0;
      r_last_k     <= '0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_last_k_out <= '0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (bus.start) begin
            r_n      <= bus.n;
            r_mode   <= (bus.mode == 2'd3) ? M_SQR : mode_t'(bus.mode);
            r_acc    <= '0;
            r_last_k <= '0;
            if (bus.n == '0) begin
              r_state      <= C_ST_DONE;
              r_result     <= '0;
              r_ovf        <= 1'b0;
              r_last_k_out <= '0;
            end else begin
              r_state <= C_ST_RUN;
            end
          end
        end
        C_ST_RUN: begin
          if (bus.abort) begin
            r_state      <= C_ST_IDLE;
            r_result     <= '0;
            r_ovf        <= 1'b0;
            r_last_k_out <= '0;
          end else if (w_over) begin
            r_state      <= C_ST_DONE;
            r_acc        <= w_ovf_acc;
            r_result     <= w_ovf_acc;
            r_ovf        <= 1'b1;
            r_last_k_out <= r_last_k;
          end else begin
            r_acc    <= w_sum[ACC_W-1:0];
            r_last_k <= w_k;
            if (w_last) begin
              r_state      <= C_ST_DONE;
              r_result     <= w_sum[ACC_W-1:0];
              r_ovf        <= 1'b0;
              r_last_k_out <= w_k;
            end
          end
        end
        C_ST_DONE: r_state <= C_ST_IDLE;
        default:   r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state == C_ST_RUN);
  assign bus.done   = (r_state == C_ST_DONE);
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;
  assign bus.last_k = r_last_k_out;

endmodule
`default_nettype wire
